load_fwd_buffer: RTL and testbench

Parametrised successor to the single-entry load stall buffer. Captures load return data (destination register, data) from the Writeback stage and holds it in a DEPTH-entry age-ordered shift buffer, so stalled or delayed Execute-stage operands can be forwarded from any of the last DEPTH loads. It also exposes NREAD independent forwarding lookup ports and the oldest-entry outputs that drive the forwarding muxes. It sits between the Execute–Writeback pipeline register / data memory read port and the Execute-stage forwarding muxes.

---
 rtl/lfb_pkg.sv | 16 +
 rtl/load_fwd_buffer_if.sv | 38 +++
 rtl/lfb_match.sv | 37 +++
 rtl/load_fwd_buffer.sv | 88 ++++++++
 tb/tb_load_fwd_buffer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfb_pkg.sv
// Shared types and constants for the load forwarding buffer.
//   REG_AW      : register address width
//   LFB_XLEN    : data width the entry type is built for
//   lfb_entry_t : one buffered load {valid, addr, data}
package lfb_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned LFB_XLEN = 32;

  typedef struct packed {
    logic                valid;
    logic [REG_AW-1:0]   addr;
    logic [LFB_XLEN-1:0] data;
  } lfb_entry_t;

endpackage

// File: rtl/load_fwd_buffer_if.sv
// Bus bundle for load_fwd_buffer.
//   master : pipeline side; drives stall/flush/write/kill/lookup addresses
//   slave  : buffer side; returns lookup results, oldest entry and count
interface load_fwd_buffer_if
  import lfb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = LFB_XLEN,
  parameter int unsigned NREAD = 2
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic                           stall;
  logic                           flush;
  logic                           wr_en;
  logic [REG_AW-1:0]              wr_addr;
  logic [XLEN-1:0]                wr_data;
  logic                           kill_en;
  logic [REG_AW-1:0]              kill_addr;
  logic [NREAD-1:0][REG_AW-1:0]   lk_addr;
  logic [NREAD-1:0]               lk_hit;
  logic [NREAD-1:0][XLEN-1:0]     lk_data;
  logic                           old_valid;
  logic [REG_AW-1:0]              old_addr;
  logic [XLEN-1:0]                old_data;
  logic [CntW-1:0]                count;

  modport master (
    output stall, flush, wr_en, wr_addr, wr_data, kill_en, kill_addr, lk_addr,
    input  lk_hit, lk_data, old_valid, old_addr, old_data, count
  );

  modport slave (
    input  stall, flush, wr_en, wr_addr, wr_data, kill_en, kill_addr, lk_addr,
    output lk_hit, lk_data, old_valid, old_addr, old_data, count
  );

endinterface

// File: rtl/lfb_match.sv
// Youngest-first priority match of one lookup address over the buffered entries.
//   ent_i  : entries, index 0 youngest
//   byp_i  : same-cycle incoming write (valid only when bypass is allowed)
//   addr_i : lookup register; x0 never hits
//   hit_o  : some valid entry (or the bypass) matched
//   data_o : data of the youngest match, 0 on miss
module lfb_match
  import lfb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  lfb_entry_t [DEPTH-1:0] ent_i,
  input  lfb_entry_t             byp_i,
  input  logic [REG_AW-1:0]      addr_i,
  output logic                   hit_o,
  output logic [LFB_XLEN-1:0]    data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (addr_i != '0) begin
      // Walk oldest to youngest so the last write left standing is the youngest match.
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        if (ent_i[i].valid && ent_i[i].addr == addr_i) begin
          hit_o  = 1'b1;
          data_o = ent_i[i].data;
        end
      end
      if (byp_i.valid && byp_i.addr == addr_i) begin
        hit_o  = 1'b1;
        data_o = byp_i.data;
      end
    end
  end

endmodule

// File: rtl/load_fwd_buffer.sv
// DEPTH-entry age-ordered buffer of recent load results with NREAD forwarding lookups.
//   clk, reset : clock; asynchronous active-high reset
//   bus        : slave side of load_fwd_buffer_if (stall/flush/write/kill/lookup in,
//                lk_hit/lk_data/old_*/count out)
// Optional build macro LFB_BYPASS_EN: lookups also see the incoming write in the same cycle.
// XLEN must equal lfb_pkg::LFB_XLEN since entries use the package entry type.
module load_fwd_buffer
  import lfb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = LFB_XLEN,
  parameter int unsigned NREAD = 2
) (
  input logic                clk,
  input logic                reset,
  load_fwd_buffer_if.slave   bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  lfb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [CntW-1:0]        count_q, count_d;
  lfb_entry_t             byp;
  logic [NREAD-1:0]       lk_hit;
  logic [NREAD-1:0][XLEN-1:0] lk_data;

  always_comb begin
    ent_d   = ent_q;
    count_d = '0;
    if (bus.flush) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_d[i].valid = 1'b0;
    end else begin
      if (!bus.stall) begin
        for (int i = int'(DEPTH) - 1; i >= 1; i--) ent_d[i] = ent_q[i-1];
        ent_d[0].valid = bus.wr_en && (bus.wr_addr != '0);
        ent_d[0].addr  = bus.wr_addr;
        ent_d[0].data  = bus.wr_data;
      end
      // Kill applies after the shift so it also covers the entry captured this edge.
      if (bus.kill_en && bus.kill_addr != '0) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (ent_d[i].addr == bus.kill_addr) ent_d[i].valid = 1'b0;
        end
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) count_d = count_d + CntW'(ent_d[i].valid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    byp = '0;
`ifdef LFB_BYPASS_EN
    byp.valid = bus.wr_en && (bus.wr_addr != '0) && !bus.flush &&
                !(bus.kill_en && bus.kill_addr == bus.wr_addr);
    byp.addr  = bus.wr_addr;
    byp.data  = bus.wr_data;
`endif
  end

  for (genvar p = 0; p < int'(NREAD); p++) begin : g_port
    lfb_match #(
      .DEPTH (DEPTH)
    ) u_match (
      .ent_i  (ent_q),
      .byp_i  (byp),
      .addr_i (bus.lk_addr[p]),
      .hit_o  (lk_hit[p]),
      .data_o (lk_data[p])
    );
  end

  assign bus.lk_hit    = lk_hit;
  assign bus.lk_data   = lk_data;
  assign bus.old_valid = ent_q[DEPTH-1].valid;
  assign bus.old_addr  = ent_q[DEPTH-1].valid ? ent_q[DEPTH-1].addr : '0;
  assign bus.old_data  = ent_q[DEPTH-1].valid ? ent_q[DEPTH-1].data : '0;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_load_fwd_buffer.sv
// Bench for load_fwd_buffer: directed literal checks plus randomized traffic compared
// every cycle against a queue-based model of the buffer.
module tb_load_fwd_buffer;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned NREAD = 2;

  logic clk;
  logic reset;
  bit   started;
  int   n_checks;
  int   n_fail;

  load_fwd_buffer_if #(.DEPTH(DEPTH), .XLEN(32), .NREAD(NREAD)) bus ();

  load_fwd_buffer #(
    .DEPTH (DEPTH),
    .XLEN  (32),
    .NREAD (NREAD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: youngest at queue front ----------------
  typedef struct {
    bit        v;
    bit [4:0]  a;
    bit [31:0] d;
  } ment_t;

  ment_t mq[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq = {};
      for (int i = 0; i < int'(DEPTH); i++) mq.push_back('{v: 1'b0, a: 5'd0, d: 32'd0});
    end else if (mq.size() == int'(DEPTH)) begin
      if (bus.flush) begin
        foreach (mq[i]) mq[i].v = 1'b0;
      end else begin
        if (!bus.stall) begin
          mq.push_front('{v: bus.wr_en && bus.wr_addr != 0, a: bus.wr_addr, d: bus.wr_data});
          void'(mq.pop_back());
        end
        if (bus.kill_en && bus.kill_addr != 0)
          foreach (mq[i]) if (mq[i].a == bus.kill_addr) mq[i].v = 1'b0;
      end
    end
  end

  function automatic void model_lookup(input bit [4:0] a, output bit h, output bit [31:0] d);
    h = 1'b0;
    d = 32'd0;
    if (a == 0) return;
`ifdef LFB_BYPASS_EN
    if (bus.wr_en && bus.wr_addr == a && !bus.flush &&
        !(bus.kill_en && bus.kill_addr == bus.wr_addr)) begin
      h = 1'b1;
      d = bus.wr_data;
      return;
    end
`endif
    foreach (mq[i]) begin
      if (mq[i].v && mq[i].a == a) begin
        h = 1'b1;
        d = mq[i].d;
        return;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started && !reset && mq.size() == int'(DEPTH)) begin
      bit        h;
      bit [31:0] d;
      int        cnt;
      cnt = 0;
      foreach (mq[i]) cnt += int'(mq[i].v);
      for (int p = 0; p < int'(NREAD); p++) begin
        model_lookup(bus.lk_addr[p], h, d);
        chk($sformatf("model lk_hit[%0d]", p), 64'(bus.lk_hit[p]), 64'(h));
        chk($sformatf("model lk_data[%0d]", p), 64'(bus.lk_data[p]), 64'(d));
      end
      chk("model old_valid", 64'(bus.old_valid), 64'(mq[DEPTH-1].v));
      chk("model old_addr", 64'(bus.old_addr), mq[DEPTH-1].v ? 64'(mq[DEPTH-1].a) : 64'd0);
      chk("model old_data", 64'(bus.old_data), mq[DEPTH-1].v ? 64'(mq[DEPTH-1].d) : 64'd0);
      chk("model count", 64'(bus.count), 64'(cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 5'd0;
    bus.wr_data   = 32'd0;
    bus.kill_en   = 1'b0;
    bus.kill_addr = 5'd0;
  endtask

  task automatic wr(input bit [4:0] a, input bit [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    started  = 1'b0;
    reset    = 1'b0;
    idle();
    bus.lk_addr = '0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    started = 1'b1;
    #1;
    chk("reset count", 64'(bus.count), 64'd0);
    chk("reset lk_hit", 64'(bus.lk_hit), 64'd0);
    chk("reset lk_data", 64'(bus.lk_data), 64'd0);
    chk("reset old_valid", 64'(bus.old_valid), 64'd0);
    chk("reset old_addr", 64'(bus.old_addr), 64'd0);
    chk("reset old_data", 64'(bus.old_data), 64'd0);

    // Two loads flow to the oldest slot and age out.
    wr(5'd5, 32'hAAAA0001);
    step();
    wr(5'd6, 32'hBBBB0002);
    bus.lk_addr[0] = 5'd5;
    #1;
    chk("x5 hit", 64'(bus.lk_hit[0]), 64'd1);
    chk("x5 data", 64'(bus.lk_data[0]), 64'hAAAA0001);
    step();
    idle();
    #1;
    chk("old_addr x5", 64'(bus.old_addr), 64'd5);
    chk("old_data x5", 64'(bus.old_data), 64'hAAAA0001);
    chk("count 2", 64'(bus.count), 64'd2);
    step();
    chk("old_addr x6", 64'(bus.old_addr), 64'd6);
    step();
    chk("old_valid aged", 64'(bus.old_valid), 64'd0);
    chk("count aged", 64'(bus.count), 64'd0);

    // Youngest duplicate wins; kill clears both.
    wr(5'd7, 32'h11);
    step();
    wr(5'd7, 32'h22);
    step();
    idle();
    bus.lk_addr[0] = 5'd7;
    #1;
    chk("x7 youngest", 64'(bus.lk_data[0]), 64'h22);
    bus.kill_en   = 1'b1;
    bus.kill_addr = 5'd7;
    step();
    idle();
    #1;
    chk("x7 kill count", 64'(bus.count), 64'd0);
    chk("x7 kill hit", 64'(bus.lk_hit[0]), 64'd0);

    // Stall holds contents and ignores writes; flush during stall empties.
    wr(5'd8, 32'h55);
    step();
    idle();
    bus.lk_addr[0] = 5'd8;
    bus.lk_addr[1] = 5'd10;
    bus.stall = 1'b1;
    wr(5'd10, 32'h99);
    repeat (3) begin
      step();
      chk("stall count", 64'(bus.count), 64'd1);
      chk("stall x8 data", 64'(bus.lk_data[0]), 64'h55);
    end
    bus.wr_en = 1'b0;
    bus.flush = 1'b1;
    #1;
    chk("stall x10 ignored", 64'(bus.lk_hit[1]), 64'd0);
    step();
    idle();
    #1;
    chk("flush count", 64'(bus.count), 64'd0);

    // x0 is never captured; write+kill of same register never stored.
    wr(5'd0, 32'hFFFF);
    bus.lk_addr[0] = 5'd0;
    step();
    idle();
    #1;
    chk("x0 count", 64'(bus.count), 64'd0);
    chk("x0 miss", 64'(bus.lk_hit[0]), 64'd0);
    wr(5'd9, 32'h9);
    bus.kill_en    = 1'b1;
    bus.kill_addr  = 5'd9;
    bus.lk_addr[0] = 5'd9;
    #1;
    chk("x9 wr+kill same cycle", 64'(bus.lk_hit[0]), 64'd0);
    step();
    idle();
    #1;
    chk("x9 wr+kill after", 64'(bus.lk_hit[0]), 64'd0);

    // Same-cycle visibility depends on the bypass build.
    wr(5'd3, 32'h1234);
    bus.lk_addr[0] = 5'd3;
    #1;
`ifdef LFB_BYPASS_EN
    chk("bypass hit", 64'(bus.lk_hit[0]), 64'd1);
    chk("bypass data", 64'(bus.lk_data[0]), 64'h1234);
`else
    chk("no bypass hit", 64'(bus.lk_hit[0]), 64'd0);
`endif
    step();
    idle();
    #1;
    chk("x3 after edge", 64'(bus.lk_data[0]), 64'h1234);

    // Asynchronous reset with two valid entries.
    wr(5'd11, 32'hB);
    step();
    wr(5'd12, 32'hC);
    step();
    idle();
    bus.lk_addr[0] = 5'd11;
    #1;
    chk("pre-reset count", 64'(bus.count), 64'd2);
    reset = 1'b1;
    #1;
    chk("async reset count", 64'(bus.count), 64'd0);
    chk("async reset hit", 64'(bus.lk_hit[0]), 64'd0);
    step();
    reset = 1'b0;
    wr(5'd13, 32'hD);
    bus.lk_addr[0] = 5'd13;
    step();
    idle();
    #1;
    chk("post-reset count", 64'(bus.count), 64'd1);
    chk("post-reset data", 64'(bus.lk_data[0]), 64'hD);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int n = 0; n < 500; n++) begin
      bus.stall     = ($urandom % 6) == 0;
      bus.flush     = ($urandom % 16) == 0;
      bus.wr_en     = ($urandom % 3) != 0;
      bus.wr_addr   = 5'($urandom % 8);
      bus.wr_data   = $urandom;
      bus.kill_en   = ($urandom % 4) == 0;
      bus.kill_addr = 5'($urandom % 8);
      for (int p = 0; p < int'(NREAD); p++) bus.lk_addr[p] = 5'($urandom % 8);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
